// File: rtl/filt_pkg.sv
// Shared widths, saturation limits and the round/saturate helper for the filter output path.
package filt_pkg;

  localparam int unsigned FILT_YW   = 40;
  localparam int unsigned FILT_OW   = 20;
  localparam int unsigned FILT_RW   = FILT_YW + 1;
  localparam int unsigned SAT_CNT_W = 16;

  localparam logic signed [FILT_RW-1:0] SAT_MAX = 41'sd524287;
  localparam logic signed [FILT_RW-1:0] SAT_MIN = -41'sd524288;
  localparam logic [FILT_OW-1:0]        OUT_MAX = 20'h7FFFF;
  localparam logic [FILT_OW-1:0]        OUT_MIN = 20'h80000;

  typedef struct packed {
    logic               sat;
    logic [FILT_OW-1:0] val;
  } s1_word_t;

  // Round half up, arithmetic shift in one extra bit so the bias carry cannot wrap, then clamp.
  function automatic s1_word_t round_sat(input logic [FILT_YW-1:0] y, input int unsigned shift);
    logic signed [FILT_RW-1:0] ext;
    logic signed [FILT_RW-1:0] bias;
    logic signed [FILT_RW-1:0] r;
    s1_word_t                  w;
    ext  = $signed({y[FILT_YW-1], y});
    bias = $signed(FILT_RW'(1) << (shift - 1));
    r    = (ext + bias) >>> shift;
    if (r > SAT_MAX) begin
      w.sat = 1'b1;
      w.val = OUT_MAX;
    end else if (r < SAT_MIN) begin
      w.sat = 1'b1;
      w.val = OUT_MIN;
    end else begin
      w.sat = 1'b0;
      w.val = FILT_OW'(r);
    end
    return w;
  endfunction

endpackage

// File: rtl/filt_outq_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO only lands if the head pops on the same edge.
module filt_outq_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop_req,
  output logic                     valid,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          full_c, pop_c, wr_c;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_c   = (level_q == LW'(DEPTH));
    pop_c    = valid_q && pop_req;
    wr_c     = push && (!full_c || pop_c);
    drop_c   = push && !wr_c;
    if (wr_c) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(wr_c) - LW'(pop_c);
    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
    end
  end

  assign valid = valid_q;
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/filt_outq.sv
// Filter output queue: round/saturate the wide filter sample, then buffer it in a FWFT FIFO.
module filt_outq
  import filt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SHIFT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pushin,
  input  logic [FILT_YW-1:0]      din,
  input  logic                    stopin,
  input  logic                    clr,
  output logic                    pushout,
  output logic [FILT_OW-1:0]      dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic [SAT_CNT_W-1:0]    sat_cnt
);

  logic                 v1_q, v1_d;
  s1_word_t             s1_q, s1_d;
  logic                 ovf_q, ovf_d;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic                 drop_c;

  // Stage 1 register plus the sticky status; a same-edge event wins over clr.
  always_comb begin
    v1_d      = pushin;
    s1_d      = s1_q;
    ovf_d     = ovf_q;
    sat_cnt_d = sat_cnt_q;
    if (pushin) begin
      s1_d = round_sat(din, SHIFT);
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end
    if (v1_q && s1_q.sat) begin
      if (clr) begin
        sat_cnt_d = SAT_CNT_W'(1);
      end else if (sat_cnt_q != '1) begin
        sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
      end
    end else if (clr) begin
      sat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      s1_q      <= '0;
      ovf_q     <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      s1_q      <= s1_d;
      ovf_q     <= ovf_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  filt_outq_fifo #(
    .DEPTH (DEPTH),
    .DW    (FILT_OW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (v1_q),
    .wdata   (s1_q.val),
    .pop_req (!stopin),
    .valid   (pushout),
    .rdata   (dout),
    .level   (level),
    .drop_c  (drop_c)
  );

  assign ovf     = ovf_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_filt_outq.sv
// Directed bench for filt_outq: per-cycle vector table plus multi-cycle FIFO/status sequences.
module tb_filt_outq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, pushin, stopin, clr;
  logic [39:0]   din;
  logic          pushout, ovf;
  logic [19:0]   dout;
  logic [LW-1:0] level;
  logic [15:0]   sat_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        pushin;
    logic [39:0] din;
    logic        exp_po;
    logic [19:0] exp_dout;
    int          exp_level;
    int          exp_sat;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  filt_outq #(.DEPTH(DEPTH), .SHIFT(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .pushin  (pushin),
    .din     (din),
    .stopin  (stopin),
    .clr     (clr),
    .pushout (pushout),
    .dout    (dout),
    .level   (level),
    .ovf     (ovf),
    .sat_cnt (sat_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic p, input logic [39:0] d, input logic s, input logic c, input logic r);
    pushin = p;
    din    = d;
    stopin = s;
    clr    = c;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic po, input int lvl, input logic ov, input int sat);
    chk({tag, ".pushout"}, 64'(pushout), 64'(po));
    chk({tag, ".level"},   64'(level),   64'(lvl));
    chk({tag, ".ovf"},     64'(ovf),     64'(ov));
    chk({tag, ".sat_cnt"}, 64'(sat_cnt), 64'(sat));
  endtask

  initial begin
    // row: pushin, din, expected pushout, dout (when valid), level, sat_cnt after the edge
    vecs[0]  = '{1'b1, 40'h0000018000, 1'b0, 20'h00000, 0, 0};
    vecs[1]  = '{1'b0, 40'h0000000000, 1'b1, 20'h00002, 1, 0};
    vecs[2]  = '{1'b0, 40'h0000000000, 1'b0, 20'h00000, 0, 0};
    vecs[3]  = '{1'b1, 40'h7FFFFFFFFF, 1'b0, 20'h00000, 0, 0};
    vecs[4]  = '{1'b1, 40'h8000000000, 1'b1, 20'h7FFFF, 1, 1};
    vecs[5]  = '{1'b1, 40'hFFFFFE8000, 1'b1, 20'h80000, 1, 2};
    vecs[6]  = '{1'b1, 40'h0000007FFF, 1'b1, 20'hFFFFF, 1, 2};
    vecs[7]  = '{1'b1, 40'h0000008000, 1'b1, 20'h00000, 1, 2};
    vecs[8]  = '{1'b0, 40'h0000000000, 1'b1, 20'h00001, 1, 2};
    vecs[9]  = '{1'b1, 40'h07FFFF0000, 1'b0, 20'h00000, 0, 2};
    vecs[10] = '{1'b1, 40'h07FFFF8000, 1'b1, 20'h7FFFF, 1, 2};
    vecs[11] = '{1'b1, 40'hF800000000, 1'b1, 20'h7FFFF, 1, 3};
    vecs[12] = '{1'b1, 40'hF7FFFF7FFF, 1'b1, 20'h80000, 1, 3};
    vecs[13] = '{1'b0, 40'h0000000000, 1'b1, 20'h80000, 1, 4};
    vecs[14] = '{1'b0, 40'h0000000000, 1'b0, 20'h00000, 0, 4};

    step(0, 40'h0, 0, 0, 1);
    step(0, 40'h0, 0, 0, 1);
    chk_state("reset", 1'b0, 0, 1'b0, 0);
    chk("reset.dout", 64'(dout), 64'(0));

    foreach (vecs[i]) begin
      step(vecs[i].pushin, vecs[i].din, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_po, vecs[i].exp_level, 1'b0, vecs[i].exp_sat);
      if (vecs[i].exp_po) chk($sformatf("vec%0d.dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end

    // Fill with stopin held: 10 pushes into 8 entries, last two dropped.
    step(0, 40'h0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      step(1, 40'(k) << 16, 1, 0, 0);
      chk($sformatf("fill%0d.level", k), 64'(level), 64'((k - 1 > 8) ? 8 : k - 1));
    end
    step(0, 40'h0, 1, 0, 0);
    step(0, 40'h0, 1, 0, 0);
    chk_state("full", 1'b1, 8, 1'b1, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d.dout", k), 64'(dout), 64'(k));
      step(0, 40'h0, 0, 0, 0);
    end
    chk_state("drained", 1'b0, 0, 1'b1, 0);

    step(0, 40'h0, 0, 1, 0);
    chk_state("clr", 1'b0, 0, 1'b0, 0);

    // Full FIFO with a same-edge pop accepts the incoming word.
    step(0, 40'h0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) step(1, 40'(k) << 16, 1, 0, 0);
    chk_state("full2", 1'b1, 8, 1'b0, 0);
    step(1, 40'(10) << 16, 0, 0, 0);
    chk_state("pp1", 1'b1, 8, 1'b0, 0);
    step(1, 40'(11) << 16, 0, 0, 0);
    chk_state("pp2", 1'b1, 8, 1'b0, 0);
    step(0, 40'h0, 0, 0, 0);
    chk_state("pp3", 1'b1, 8, 1'b0, 0);
    for (int k = 4; k <= 11; k++) begin
      chk($sformatf("pp_order%0d", k), 64'(dout), 64'(k));
      step(0, 40'h0, 0, 0, 0);
    end
    chk_state("pp_empty", 1'b0, 0, 1'b0, 0);

    // Reset with stored words and stage 1 valid.
    step(0, 40'h0, 0, 0, 1);
    for (int k = 1; k <= 6; k++) step(1, 40'(k) << 16, 1, 0, 0);
    chk("pre_rst.level", 64'(level), 64'(5));
    pushin = 1'b1; din = 40'h7FFFFFFFFF; clr = 1'b1; stopin = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk_state("mid_rst", 1'b0, 0, 1'b0, 0);
    chk("mid_rst.dout", 64'(dout), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step(0, 40'h0, 0, 0, 0);
      chk_state($sformatf("post_rst%0d", k), 1'b0, 0, 1'b0, 0);
    end

    // Drop and saturation on the same edge as clr take priority.
    step(0, 40'h0, 0, 0, 1);
    for (int k = 0; k < 9; k++) step(1, 40'h7FFFFFFFFF, 1, 0, 0);
    chk_state("satfull", 1'b1, 8, 1'b0, 8);
    step(0, 40'h0, 1, 1, 0);
    chk_state("clr_vs_evt", 1'b1, 8, 1'b1, 1);
    step(0, 40'h0, 1, 1, 0);
    chk_state("clr_alone", 1'b1, 8, 1'b0, 0);

    // sat_cnt holds at its ceiling.
    step(0, 40'h0, 0, 0, 1);
    for (int k = 0; k < 65540; k++) step(1, 40'h7FFFFFFFFF, 0, 0, 0);
    step(0, 40'h0, 0, 0, 0);
    step(0, 40'h0, 0, 0, 0);
    chk_state("sat_max", 1'b0, 0, 1'b0, 65535);
    step(0, 40'h0, 0, 1, 0);
    chk_state("sat_clr", 1'b0, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/filt_outq.md
FILT_OUTQ -- requirements
Module: filt_outq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter SHIFT, default 16, right-shift applied to filter output before narrowing (1..20).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pushin  input  1  upstream filter output valid (filter pushout); no backpressure to upstream.
REQ-006 SHALL have port din  input  40  signed filter output sample y.
REQ-007 SHALL have port stopin  input  1  downstream not ready; holds head word.
REQ-008 SHALL have port clr  input  1  clears ovf and sat_cnt.
REQ-009 SHALL have port pushout  output  1  dout valid (FIFO non-empty).
REQ-010 SHALL have port dout  output  20  signed rounded/saturated sample at FIFO head.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port ovf  output  1  sticky: a sample was dropped on full.
REQ-013 SHALL have port sat_cnt  output  16  count of saturated samples, saturating at 65535.

Function
REQ-014 Stage 1 SHALL compute r = (din + 2^(SHIFT-1)) >>> SHIFT in 41-bit signed arithmetic (round half up, no wrap on carry).
REQ-015 Stage 1 SHALL saturate r to [-524288, 524287]; result and a sat bit registered on the edge where pushin=1, with a registered valid v1.
REQ-016 sat_cnt SHALL increment by 1 on each edge where v1=1 and sat bit=1, holding at 65535.
REQ-017 On the edge where v1=1 the stage-1 word SHALL be written at FIFO tail if not full, or if full and a pop occurs on the same edge.
REQ-018 If v1=1, FIFO full and no pop on that edge, the word SHALL be discarded and ovf set to 1; FIFO contents unchanged.
REQ-019 FIFO SHALL be first-word-fall-through: pushout = (level != 0), dout = head entry; dout value undefined-free (holds last head) when empty is not required.
REQ-020 A pop SHALL occur on an edge where pushout=1 and stopin=0; head advances, level decrements.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, valid at any level including 0 < level <= DEPTH.
REQ-022 Push into empty FIFO SHALL NOT bypass: sample on pushin at edge k yields pushout=1 after edge k+1 (latency 2 cycles).
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor go below 0.
REQ-024 stopin while pushout=0 SHALL have no effect.
REQ-025 clr=1 SHALL zero ovf and sat_cnt on that edge; a same-edge drop or saturation SHALL take priority (ovf=1, sat_cnt=1).
REQ-026 Throughput SHALL be one sample per clock with stopin=0.

Reset
REQ-027 reset=1 at an edge SHALL clear v1, pointers, level=0, pushout=0, dout=0, ovf=0, sat_cnt=0, discarding in-flight and stored samples.
REQ-028 Reset SHALL take priority over pushin, clr and pops on the same edge; pushin during reset is ignored.

Structure
REQ-029 Widths (FILT_YW=40, FILT_OW=20) and saturation limits SHALL live in shared package filt_pkg.
REQ-030 FIFO storage/pointers SHALL be a sub-module filt_outq_fifo (sync FWFT, DEPTH parameter); round/saturate stays in filt_outq.

Verification
REQ-031 SHIFT=16, din=0x0000018000 pushin one cycle, stopin=0 -> pushout high 2 cycles later for 1 cycle, dout=2, sat_cnt=0.
REQ-032 din=0x7FFFFFFFFF, then din=0x8000000000 -> dout=524287 then -524288, sat_cnt=2.
REQ-033 stopin=1, 10 consecutive pushin (din=k<<16, k=1..10), DEPTH=8 -> level=8, ovf=1, releasing stopin yields dout 1..8 in order.
REQ-034 FIFO full, stopin=0 and pushin same cycle -> no drop, ovf stays 0, level stays 8, order preserved.
REQ-035 reset asserted with level=5 and stage 1 valid -> next cycle pushout=0, level=0, no stale output after release.
REQ-036 sat_cnt driven to 65535 by 65540 saturating samples -> holds 65535; clr alone -> 0.
